// File: rtl/expr_result_checker.sv
// expr_result_checker
// Response-side checker for the generated expression blocks. Each accepted
// beat of the 90-bit result bus is split into 18 fields (widths 4,5,6
// repeating, y0 at the top) and compared against the expected vector.
// Mismatching vectors are counted, the first failure is captured, and every
// accepted result is folded into a 32-bit MISR signature.
module expr_result_checker #(
    parameter int          CNT_W = 16,
    parameter logic [31:0] POLY  = 32'h04C11DB7,
    parameter logic [31:0] SEED  = 32'hFFFFFFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vectors,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [89:0]      y,
    input  logic [89:0]      y_exp,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [17:0]      first_err_mask,
    output logic [31:0]      signature
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nx;
    logic [CNT_W-1:0] num_r;
    logic [CNT_W-1:0] num_nx;
    logic [CNT_W-1:0] vec_idx_r;
    logic [CNT_W-1:0] vec_idx_nx;
    logic [CNT_W-1:0] err_nx;
    logic [CNT_W-1:0] first_idx_nx;
    logic [17:0]      first_mask_nx;
    logic [31:0]      sig_nx;
    logic             pass_nx;

    logic             accept_s;
    logic             start_ok_s;
    logic             last_s;
    logic [17:0]      mask_s;
    logic             err_hit_s;

    // Per-field mismatch mask. Field k starts at the bit just below field k-1
    // and is 4 + (k mod 3) bits wide; the inner loop runs to the widest field
    // and masks off bits that do not belong to the current one.
    function automatic logic [17:0] field_mismatch(input logic [89:0] a,
                                                   input logic [89:0] b);
        logic [17:0] m;
        int          msb;
        int          w;
        m   = 18'd0;
        msb = 89;
        for (int k = 0; k < 18; k++) begin
            w = 4 + (k % 3);
            for (int bi = 0; bi < 6; bi++) begin
                m[k] = m[k] | ((bi < w) & (a[msb - bi] ^ b[msb - bi]));
            end
            msb = msb - w;
        end
        return m;
    endfunction

    // One MISR step: shift left, reduce by POLY on carry-out, inject the fold
    // of the three 32-bit-aligned chunks of the result bus.
    function automatic logic [31:0] misr_step(input logic [31:0] sig,
                                              input logic [89:0] d);
        logic [31:0] fold;
        fold = d[31:0] ^ d[63:32] ^ {6'b0, d[89:64]};
        return {sig[30:0], 1'b0} ^ (sig[31] ? POLY : 32'h0000_0000) ^ fold;
    endfunction

    // in_ready is registered and high exactly in RUN, so it gates acceptance.
    assign accept_s   = in_valid & in_ready;
    assign start_ok_s = start & ((state_r == ST_IDLE) | (state_r == ST_DONE));
    assign mask_s     = field_mismatch(y, y_exp);
    assign err_hit_s  = |mask_s;
    assign last_s     = (vec_idx_r == (num_r - CNT_W'(1)));

    // Next-state and next-value computation for the FSM and all status.
    always_comb begin
        state_nx      = state_r;
        num_nx        = num_r;
        vec_idx_nx    = vec_idx_r;
        err_nx        = err_count;
        first_idx_nx  = first_err_idx;
        first_mask_nx = first_err_mask;
        sig_nx        = signature;
        pass_nx       = pass;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start_ok_s) begin
                    num_nx        = num_vectors;
                    vec_idx_nx    = {CNT_W{1'b0}};
                    err_nx        = {CNT_W{1'b0}};
                    first_idx_nx  = {CNT_W{1'b0}};
                    first_mask_nx = 18'd0;
                    sig_nx        = SEED;
                    if (num_vectors == {CNT_W{1'b0}}) begin
                        state_nx = ST_DONE;
                        pass_nx  = 1'b1;
                    end else begin
                        state_nx = ST_RUN;
                        pass_nx  = 1'b0;
                    end
                end else begin
                    state_nx = state_r;
                end
            end
            ST_RUN: begin
                pass_nx = 1'b0;
                if (accept_s) begin
                    vec_idx_nx = vec_idx_r + CNT_W'(1);
                    sig_nx     = misr_step(signature, y);
                    if (err_hit_s) begin
                        // First error of the run is recognised by a zero count;
                        // the count saturates so it never returns to zero.
                        if (err_count == {CNT_W{1'b0}}) begin
                            first_idx_nx  = vec_idx_r;
                            first_mask_nx = mask_s;
                        end else begin
                            first_idx_nx  = first_err_idx;
                        end
                        if (err_count != {CNT_W{1'b1}}) begin
                            err_nx = err_count + CNT_W'(1);
                        end else begin
                            err_nx = err_count;
                        end
                    end else begin
                        err_nx = err_count;
                    end
                    if (last_s) begin
                        state_nx = ST_DONE;
                        pass_nx  = ~err_hit_s & (err_count == {CNT_W{1'b0}});
                    end else begin
                        state_nx = ST_RUN;
                    end
                end else begin
                    state_nx = ST_RUN;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                pass_nx  = 1'b0;
            end
        endcase
    end

    // State and registered status outputs; async reset discards any run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            num_r          <= {CNT_W{1'b0}};
            vec_idx_r      <= {CNT_W{1'b0}};
            in_ready       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= {CNT_W{1'b0}};
            first_err_idx  <= {CNT_W{1'b0}};
            first_err_mask <= 18'd0;
            signature      <= 32'h0000_0000;
        end else begin
            state_r        <= state_nx;
            num_r          <= num_nx;
            vec_idx_r      <= vec_idx_nx;
            in_ready       <= (state_nx == ST_RUN);
            busy           <= (state_nx == ST_RUN);
            done           <= (state_nx == ST_DONE);
            pass           <= pass_nx;
            err_count      <= err_nx;
            first_err_idx  <= first_idx_nx;
            first_err_mask <= first_mask_nx;
            signature      <= sig_nx;
        end
    end

endmodule

// File: tb/tb_expr_result_checker.sv
// Directed + randomized bench for expr_result_checker with a behavioural
// reference model (field slicing by shift/mask, MISR by plain arithmetic).
module tb_expr_result_checker;

    localparam logic [31:0] POLY = 32'h04C11DB7;
    localparam logic [31:0] SEED = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] num_vectors;
    logic        in_valid;
    logic        in_ready;
    logic [89:0] y;
    logic [89:0] y_exp;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] err_count;
    logic [15:0] first_err_idx;
    logic [17:0] first_err_mask;
    logic [31:0] signature;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int          m_err;
    int          m_first_idx;
    logic [17:0] m_first_mask;
    logic [31:0] m_sig;
    int          m_idx;

    expr_result_checker dut (
        .clk(clk), .rst(rst), .start(start), .num_vectors(num_vectors),
        .in_valid(in_valid), .in_ready(in_ready), .y(y), .y_exp(y_exp),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_idx(first_err_idx), .first_err_mask(first_err_mask),
        .signature(signature)
    );

    always #5 clk = ~clk;

    function automatic logic [89:0] rand90();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[89:0];
    endfunction

    function automatic logic [17:0] ref_mask(input logic [89:0] a, input logic [89:0] b);
        logic [17:0] m;
        logic [89:0] fm;
        int          lsb;
        int          w;
        m   = 18'd0;
        lsb = 90;
        for (int k = 0; k < 18; k++) begin
            w   = 4 + k % 3;
            lsb = lsb - w;
            fm  = (90'd1 << w) - 90'd1;
            m[k] = (((a >> lsb) & fm) != ((b >> lsb) & fm));
        end
        return m;
    endfunction

    function automatic logic [31:0] ref_sig(input logic [31:0] s, input logic [89:0] d);
        logic [63:0] t;
        logic [89:0] hi;
        hi = d >> 64;
        t  = {32'd0, s} << 1;
        if (s[31]) t = t ^ {32'd0, POLY};
        t = t ^ {32'd0, d[31:0]} ^ {32'd0, d[63:32]} ^ {32'd0, hi[31:0]};
        return t[31:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_done"}, {63'd0, done}, 64'd0);
        chk({tag, "_pass"}, {63'd0, pass}, 64'd0);
        chk({tag, "_err"}, {48'd0, err_count}, 64'd0);
        chk({tag, "_fidx"}, {48'd0, first_err_idx}, 64'd0);
        chk({tag, "_fmask"}, {46'd0, first_err_mask}, 64'd0);
        chk({tag, "_sig"}, {32'd0, signature}, 64'd0);
    endtask

    // start pulse for one cycle; model is cleared as a new run begins
    task automatic do_start(input int n);
        @(negedge clk);
        start       = 1'b1;
        num_vectors = n[15:0];
        in_valid    = 1'b0;
        m_err = 0; m_first_idx = 0; m_first_mask = 18'd0; m_sig = SEED; m_idx = 0;
        @(negedge clk);
        start = 1'b0;
    endtask

    // present one beat (after a random idle gap with junk data), wait for accept
    task automatic send_beat(input logic [89:0] yv, input logic [89:0] ev);
        int          bound;
        logic [17:0] mk;
        repeat ($urandom_range(0, 2)) begin
            in_valid = 1'b0;
            y        = rand90();
            y_exp    = rand90();
            @(negedge clk);
        end
        in_valid = 1'b1;
        y        = yv;
        y_exp    = ev;
        bound    = 0;
        while (!in_ready && bound < 20) begin
            @(negedge clk);
            bound++;
        end
        if (bound >= 20) begin
            chk("ready_timeout", {63'd0, in_ready}, 64'd1);
        end else begin
            @(negedge clk);
            in_valid = 1'b0;
            mk = ref_mask(yv, ev);
            if (mk != 18'd0) begin
                if (m_err == 0) begin
                    m_first_idx  = m_idx;
                    m_first_mask = mk;
                end
                if (m_err < 65535) m_err++;
            end
            m_sig = ref_sig(m_sig, yv);
            m_idx++;
            chk("beat_err", {48'd0, err_count}, 64'(m_err));
            chk("beat_sig", {32'd0, signature}, {32'd0, m_sig});
        end
    endtask

    task automatic check_done(input string tag);
        chk({tag, "_done"}, {63'd0, done}, 64'd1);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
        chk({tag, "_pass"}, {63'd0, pass}, {63'd0, (m_err == 0)});
        chk({tag, "_err"}, {48'd0, err_count}, 64'(m_err));
        chk({tag, "_fidx"}, {48'd0, first_err_idx}, 64'(m_first_idx));
        chk({tag, "_fmask"}, {46'd0, first_err_mask}, {46'd0, m_first_mask});
        chk({tag, "_sig"}, {32'd0, signature}, {32'd0, m_sig});
    endtask

    initial begin
        logic [89:0] e;
        logic [89:0] v;
        logic [89:0] one;
        rst = 1'b1; start = 1'b0; num_vectors = 16'd0; in_valid = 1'b0;
        y = 90'd0; y_exp = 90'd0;
        m_err = 0; m_first_idx = 0; m_first_mask = 18'd0; m_sig = 32'd0; m_idx = 0;
        one = 90'd1;

        // reset state
        @(negedge clk);
        chk_zero_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // zero-length run goes straight to DONE with pass and seed signature
        do_start(0);
        check_done("zero_run");
        chk("zero_run_sig_const", {32'd0, signature}, 64'hFFFFFFFF);
        @(negedge clk);
        chk("zero_run_ready_hold", {63'd0, in_ready}, 64'd0);

        // single all-zero vector
        do_start(1);
        send_beat(90'd0, 90'd0);
        check_done("one_zero");
        chk("one_zero_sig_const", {32'd0, signature}, 64'hFB3EE249);

        // three vectors: y17 error, then y0 error which must not overwrite capture
        do_start(3);
        e = rand90();
        send_beat(e, e);
        e = rand90();
        send_beat(e ^ one, e);
        e = rand90();
        send_beat(e ^ (one << 89), e);
        check_done("three");
        chk("three_err_const", {48'd0, err_count}, 64'd2);
        chk("three_fidx_const", {48'd0, first_err_idx}, 64'd1);
        chk("three_fmask_const", {46'd0, first_err_mask}, 64'h20000);
        chk("three_pass_const", {63'd0, pass}, 64'd0);

        // in_valid high while DONE must not update anything
        in_valid = 1'b1;
        repeat (3) begin
            y = rand90(); y_exp = rand90();
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_done("done_idle_valid");

        // ten random vectors with random valid gaps, ~half with a flipped bit
        do_start(10);
        for (int i = 0; i < 10; i++) begin
            e = rand90();
            v = e;
            if ($urandom_range(0, 1) == 1) v[$urandom_range(0, 89)] = ~v[$urandom_range(0, 89)];
            send_beat(v, e);
        end
        check_done("rand10");
        in_valid = 1'b1;
        repeat (4) begin
            y = rand90(); y_exp = rand90();
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_done("rand10_after");

        // reset in the middle of an 8-vector run
        do_start(8);
        for (int i = 0; i < 4; i++) begin
            e = rand90();
            send_beat(e ^ (one << i), e);
        end
        chk("mid_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        #1;
        chk_zero_outputs("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        do_start(2);
        e = rand90();
        send_beat(e, e);
        e = rand90();
        send_beat(e ^ (one << 40), e);
        check_done("after_rst");
        chk("after_rst_err_const", {48'd0, err_count}, 64'd1);

        // start while DONE restarts with a full clear
        do_start(3);
        chk("restart_busy", {63'd0, busy}, 64'd1);
        chk("restart_done", {63'd0, done}, 64'd0);
        chk("restart_err", {48'd0, err_count}, 64'd0);
        chk("restart_fmask", {46'd0, first_err_mask}, 64'd0);
        chk("restart_sig", {32'd0, signature}, {32'd0, SEED});
        e = rand90();
        send_beat(e ^ (one << 70), e);
        // start while RUN is ignored
        start = 1'b1; num_vectors = 16'd1;
        @(negedge clk);
        start = 1'b0;
        chk("run_start_busy", {63'd0, busy}, 64'd1);
        chk("run_start_err", {48'd0, err_count}, 64'(m_err));
        e = rand90();
        send_beat(e, e);
        e = rand90();
        send_beat(e ^ (one << 3), e);
        check_done("run_start");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/expr_result_checker.md
Name: expr_result_checker

Overview:
- Response-side companion for the generated expression blocks. It accepts the 90-bit packed result bus y = {y0..y17} of an expression block, together with the expected vector for each beat.
- Splits each beat into its 18 fields and compares them field by field. Counts mismatching vectors, records the first failure and folds every accepted result into a 32-bit MISR signature.
- Sits between the expression DUT wrapper and the regression controller. Runs a programmed number of vectors and then reports pass/fail.

Parameters:
- CNT_W, 16, width of the vector counter, num_vectors, err_count and first_err_idx.
- POLY, 32'h04C11DB7, MISR feedback polynomial.
- SEED, 32'hFFFFFFFF, MISR value loaded on start.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse that begins a run; honoured only in IDLE or DONE.
- num_vectors  in  CNT_W  number of beats to accept; sampled on start.
- in_valid  in  1  result beat valid.
- in_ready  out  1  checker accepts a beat; high only in RUN.
- y  in  90  result bus from the expression block.
- y_exp  in  90  expected result for the same beat.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass  out  1  valid while done; 1 iff err_count==0.
- err_count  out  CNT_W  number of vectors with at least one mismatching field; saturates at all-ones.
- first_err_idx  out  CNT_W  index (0-based) of the first mismatching vector.
- first_err_mask  out  18  per-field mismatch mask of that vector; bit k = field yk.
- signature  out  32  MISR value.

Behaviour:
- Field map: yk occupies a slice whose MSB is 89 minus the summed widths of y0..y(k-1). Width of yk is 4 + (k mod 3).
  - y0 = [89:86], y1 = [85:81], y2 = [80:75], …, y17 = [5:0].
- Reset (async, immediate): state IDLE; in_ready, busy, done, pass = 0; err_count, first_err_idx = 0; first_err_mask = 0; signature = 0.
- FSM states IDLE, RUN, DONE:
  - IDLE, start=1: latch num_vectors, clear vector counter, err_count, first_err_idx and first_err_mask, load signature = SEED.
    - If num_vectors == 0, go to DONE (pass=1, signature=SEED).
    - Otherwise go to RUN.
  - RUN: in_ready=1. A beat is accepted when in_valid & in_ready. start is ignored.
  - RUN, accept of beat number num_vectors-1: go to DONE on the next edge.
  - DONE: done=1 and all results held. start behaves as in IDLE, giving a new run with a full clear.
  - start in IDLE/DONE also clears done/pass on the same edge.
- Per accepted beat:
  - mask[k] = (field k of y) != (field k of y_exp).
  - If mask != 0:
    - err_count increments, saturating.
    - If this is the first error of the run, capture first_err_idx = current vector index and first_err_mask = mask. Later errors never overwrite them.
- MISR update, once per accepted beat, using pre-update sig:
  - fold = y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]}.
  - sig' = {sig[30:0],1'b0} ^ (sig[31] ? POLY : 0) ^ fold.
- Latency: every status output is registered.
  - err_count, first_err_*, signature reflect beat N on the cycle after it is accepted.
  - done rises on the cycle after the final accept, and is coincident with the final update.
- in_valid while in_ready=0 is not a beat: no state change, no update.
- Vector counter and err_count are CNT_W wide. A run of 2^CNT_W − 1 vectors must complete correctly.
- rst asserted mid-RUN: immediate return to reset values. A partially accepted run is discarded.

Test Plan:
- Reset, then start with num_vectors=0 → next cycle done=1, pass=1, err_count=0, signature=32'hFFFFFFFF, in_ready never high.
- Run of num_vectors=1 with y=y_exp=0 → signature=32'hFB3EE249, pass=1, err_count=0.
- Run of 3 vectors; beat 1 has y=y_exp^90'h1 (bit 0 of y inverted) and beat 2 has y=y_exp^(1<<89) → err_count=2, first_err_idx=1, first_err_mask=18'h20000 (y17), pass=0. The y0 error (mask 18'h00001) must not overwrite the first capture.
- Toggle in_valid randomly over a 10-vector run and drive in_valid=1 in IDLE and DONE → exactly 10 accepts. Signature matches the reference model; no updates outside RUN.
- Assert rst after 4 of 8 vectors → outputs return to 0 immediately. A new start with num_vectors=2 completes with only the 2 new beats counted.
- Pulse start again while done=1 and while busy=1 → the DONE pulse restarts and clears counters; the RUN pulse is ignored and the run finishes unaffected.
